// File: rtl/uni_shift_seq.sv
// Universal shift register with a multi-step command sequencer.
// Single-cycle commands (HOLD, LOAD, CLEAR, or any shift with count=0) update q
// at the acceptance edge. A shift with count N>=1 latches mode/count, then
// performs one step per edge for N edges. An abort ends the run early and
// leaves q partly shifted; a run that completes pulses done for one cycle.
module uni_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] d,
  input  logic             dl,
  input  logic             dr,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             so_lo,
  output logic             so_hi,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHR   = 3'b001,
    M_SHL   = 3'b010,
    M_LOAD  = 3'b011,
    M_ROR   = 3'b100,
    M_ROL   = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state, state_next;
  mode_e            mode_r, mode_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic [WIDTH-1:0] q_next;
  logic             done_next;
  mode_e            mode_in;
  logic             accept;
  logic             is_shift;

  // One step of a shift or rotate; dl/dr are the values present at the step edge.
  function automatic logic [WIDTH-1:0] step(input mode_e m,
                                            input logic [WIDTH-1:0] v,
                                            input logic fill_l,
                                            input logic fill_r);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_SHR:   r = {fill_r, v[WIDTH-1:1]};
      M_SHL:   r = {v[WIDTH-2:0], fill_l};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign mode_in   = mode_e'(mode);
  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign is_shift  = (mode_in == M_SHR) || (mode_in == M_SHL) || (mode_in == M_ROR) ||
                     (mode_in == M_ROL) || (mode_in == M_ASR);
  assign busy      = (state == RUN);
  assign so_lo     = q[0];
  assign so_hi     = q[WIDTH-1];

  // State, register contents, latched command and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      mode_r <= M_HOLD;
      cnt_r  <= '0;
      q      <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      mode_r <= mode_next;
      cnt_r  <= cnt_next;
      q      <= q_next;
      done   <= done_next;
    end
  end

  // Command acceptance, step sequencing and abort handling.
  always_comb begin
    state_next = state;
    mode_next  = mode_r;
    cnt_next   = cnt_r;
    q_next     = q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_shift && (count != '0)) begin
            state_next = RUN;
            mode_next  = mode_in;
            cnt_next   = count;
          end else begin
            done_next = 1'b1;
            case (mode_in)
              M_LOAD:  q_next = d;
              M_CLEAR: q_next = '0;
              default: q_next = q;
            endcase
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          q_next   = step(mode_r, q, dl, dr);
          cnt_next = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/uni_shift_seq.md
UNI_SHIFT_SEQ -- requirements
Module: uni_shift_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock is the only clock and reset is the only reset.
REQ-002 The block SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 4, width of the shift-count field (>= 1).
REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous clear, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- mode  in  3  operation code, listed in REQ-005.
- count  in  CNT_W  number of shift steps.
- d  in  WIDTH  parallel load data.
- dl  in  1  serial fill bit into q[0] (SHL).
- dr  in  1  serial fill bit into q[WIDTH-1] (SHR).
- abort  in  1  cancels a running shift.
- q  out  WIDTH  register contents.
- so_lo  out  1  equals q[0].
- so_hi  out  1  equals q[WIDTH-1].
- busy  out  1  multi-step shift in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-004 A command SHALL be accepted at a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 exactly when the state is IDLE and reset=0.
REQ-005 Mode encoding, with one step defined as:
- 000 HOLD: no change.
- 001 SHR: q[i] <= q[i+1]; MSB <= dr.
- 010 SHL: q[i] <= q[i-1]; q[0] <= dl.
- 011 LOAD: q <= d.
- 100 ROR: q[i] <= q[i+1]; MSB <= old q[0].
- 101 ROL: q[i] <= q[i-1]; q[0] <= old MSB.
- 110 ASR: q[i] <= q[i+1]; MSB is kept.
- 111 CLEAR: q <= 0.
REQ-006 Single-cycle commands SHALL update q at the acceptance edge, keep the state IDLE, and assert done=1 for the following cycle. Single-cycle commands are HOLD, LOAD, CLEAR, and any shift mode (001, 010, 100, 101, 110) with count=0.
REQ-007 For a shift command with count=N>=1 accepted at edge k, the acceptance edge SHALL latch mode and N without changing q. The block SHALL then be in RUN during the cycles between edge k and edge k+N, with busy=1.
REQ-008 In RUN the block SHALL perform exactly one step per edge, at edges k+1 through k+N. It SHALL return to IDLE at edge k+N and assert done=1 for the one cycle after edge k+N, during which q already holds the final value.
REQ-009 dl and dr SHALL be sampled at each step edge, not latched at acceptance. mode, count and d SHALL be ignored while in RUN.
REQ-010 Counts larger than WIDTH SHALL be honoured literally. For example, ROL by WIDTH returns the original value, and SHR by WIDTH or more fills every bit with the dr value sampled at the respective step edges.
REQ-011 abort=1 at an edge in RUN SHALL return the block to IDLE without performing that step. q SHALL keep its partially shifted value and done SHALL stay 0.
REQ-012 abort SHALL be ignored in IDLE. cmd_valid in RUN SHALL be ignored and not queued.
REQ-013 Only one FSM state register SHALL exist, with two states (IDLE, RUN). busy SHALL be (state==RUN). done SHALL never coincide with busy=1.
REQ-014 so_lo and so_hi SHALL be combinational copies of q[0] and q[WIDTH-1].

Reset
REQ-015 reset=1 at an edge SHALL set q=0, state=IDLE, the remaining count to 0 and done=0, regardless of any other input, including mid-RUN and with abort or cmd_valid active.
REQ-016 While reset=1, cmd_ready SHALL be 0 and busy SHALL be 0 from the first edge on. The first command SHALL be accepted at the first edge with reset=0.

Verification (WIDTH=8, CNT_W=4)
REQ-017 Reset: hold reset for 2 cycles with cmd_valid=1 and mode=LOAD -> q=0x00, busy=0, cmd_ready=0 during reset and 1 after, no load occurs.
REQ-018 Load: LOAD d=0xA5 -> q=0xA5 after the edge, done=1 for exactly one cycle, busy stays 0.
REQ-019 Shift right: from 0xA5, SHR count=3 with dr=1 -> q steps 0xD2, 0xE9, 0xF4; busy=1 for 3 cycles; done=1 with q=0xF4; cmd_ready=0 throughout.
REQ-020 Rotate and arithmetic shift:
- From 0x81, ROL count=8 -> q=0x81 at done.
- From 0x81, ROR count=1 -> q=0xC0.
- From 0x90, ASR count=2 -> q steps 0xC8, 0xE4.
REQ-021 Abort: from 0x01, SHL count=5 with dl=0, abort asserted after 2 steps -> q=0x04, busy=0 next cycle, done never pulses, a new LOAD is accepted at the next edge.
REQ-022 Reset mid-run and count 0: reset during a RUN of SHR count=9 -> q=0x00 and IDLE at that edge; a later SHR count=0 -> q unchanged, done pulse, busy never 1.
